// File: rtl/alu_mul_sequencer.sv
// Shift-and-add MUL sequencer that borrows the datapath ALU for one ADD per
// multiplier bit and returns the low WIDTH bits of the product.
module alu_mul_sequencer #(
   parameter int         WIDTH   = 32,
   parameter logic [3:0] ALU_ADD = 4'b0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] multiplicand_i,
   input  logic [WIDTH-1:0] multiplier_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o,
   output logic [3:0]       ALU_Operation_o,
   output logic [WIDTH-1:0] ALU_A_o,
   output logic [WIDTH-1:0] ALU_B_o,
   input  logic [WIDTH-1:0] ALU_Result_i
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] mplier_next;

   // The ALU sum is only taken when the current multiplier bit is set.
   always_comb begin
      acc_next    = mplier[0] ? ALU_Result_i : acc;
      mplier_next = mplier >> 1;
   end

   assign ALU_Operation_o = ALU_ADD;
   assign ALU_A_o         = (state == RUN) ? acc   : '0;
   assign ALU_B_o         = (state == RUN) ? mcand : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         product_o <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  acc    <= '0;
                  mcand  <= multiplicand_i;
                  mplier <= multiplier_i;
                  busy_o <= 1'b1;
                  if (multiplier_i == '0) begin
                     state     <= DONE;
                     done_o    <= 1'b1;
                     product_o <= '0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier_next;
               // Stop as soon as no set bits remain; product includes this add.
               if (mplier_next == '0) begin
                  state     <= DONE;
                  done_o    <= 1'b1;
                  product_o <= acc_next;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_o <= 1'b0;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               done_o <= 1'b0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ADD-only ALU in the loop.
module tb_alu_mul_sequencer;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             start_i;
   logic [WIDTH-1:0] multiplicand_i;
   logic [WIDTH-1:0] multiplier_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] product_o;
   logic [3:0]       ALU_Operation_o;
   logic [WIDTH-1:0] ALU_A_o;
   logic [WIDTH-1:0] ALU_B_o;
   logic [WIDTH-1:0] ALU_Result_i;

   int n_checks = 0;
   int n_fails  = 0;

   alu_mul_sequencer #(.WIDTH(WIDTH), .ALU_ADD(4'b0000)) dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .multiplicand_i  (multiplicand_i),
      .multiplier_i    (multiplier_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .product_o       (product_o),
      .ALU_Operation_o (ALU_Operation_o),
      .ALU_A_o         (ALU_A_o),
      .ALU_B_o         (ALU_B_o),
      .ALU_Result_i    (ALU_Result_i)
   );

   always #5 clk = ~clk;

   // Datapath ALU stand-in: only ADD is ever requested.
   assign ALU_Result_i = (ALU_Operation_o == 4'b0000) ? ALU_A_o + ALU_B_o : 32'hDEADBEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one multiply, measure edges from E0 to done_o, then step into the
   // first IDLE cycle. pulse_at > 0 raises start_i (A=9,B=9) that many cycles after E0.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_prod, input int exp_lat,
                         input int pulse_at, input bit chk_alu_zero);
      int  n;
      bit  op_bad;
      bit  alu_nz;
      @(negedge clk);
      start_i        = 1'b1;
      multiplicand_i = a;
      multiplier_i   = b;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      n       = 1;
      op_bad  = 1'b0;
      alu_nz  = 1'b0;
      check({tag, "_busy_after_e0"}, 32'(busy_o), 32'd1);
      while (!done_o && n <= 60) begin
         if (ALU_Operation_o != 4'b0000) op_bad = 1'b1;
         if (ALU_A_o != '0 || ALU_B_o != '0) alu_nz = 1'b1;
         start_i = (pulse_at > 0 && n == pulse_at);
         if (pulse_at > 0 && n == pulse_at) begin
            multiplicand_i = 32'd9;
            multiplier_i   = 32'd9;
         end
         @(posedge clk);
         #1;
         n++;
      end
      start_i = 1'b0;
      if (!done_o) begin
         check({tag, "_timeout"}, 32'(n), 32'(exp_lat));
      end else begin
         check({tag, "_latency"}, 32'(n), 32'(exp_lat));
         check({tag, "_product"}, product_o, exp_prod);
         check({tag, "_busy_in_done"}, 32'(busy_o), 32'd1);
         check({tag, "_alu_op"}, 32'(op_bad), 32'd0);
         if (chk_alu_zero) check({tag, "_alu_ab_zero"}, 32'(alu_nz), 32'd0);
         @(posedge clk);
         #1;
         check({tag, "_done_one_cycle"}, 32'(done_o), 32'd0);
         check({tag, "_busy_clear"}, 32'(busy_o), 32'd0);
         check({tag, "_product_held"}, product_o, exp_prod);
      end
   endtask

   initial begin
      bit saw_done;
      reset          = 1'b1;
      start_i        = 1'b0;
      multiplicand_i = '0;
      multiplier_i   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_busy",    32'(busy_o), 32'd0);
      check("rst_done",    32'(done_o), 32'd0);
      check("rst_product", product_o,   32'd0);
      check("rst_alu_a",   ALU_A_o,     32'd0);
      check("rst_alu_b",   ALU_B_o,     32'd0);
      check("rst_alu_op",  32'(ALU_Operation_o), 32'd0);

      run_op("6x7",      32'd6,        32'd7,        32'h0000002A, 4,  0, 1'b0);
      run_op("zero_b",   32'h12345678, 32'd0,        32'h00000000, 1,  0, 1'b1);
      run_op("ones",     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 0, 1'b0);
      run_op("neg3x5",   32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 4,  0, 1'b0);
      run_op("ign_start",32'd3,        32'h80000000, 32'h80000000, 33, 5, 1'b0);
      run_op("b2b_9x9",  32'd9,        32'd9,        32'd81,       5,  0, 1'b0);

      // Abort a long multiply with a one-cycle reset.
      @(negedge clk);
      start_i        = 1'b1;
      multiplicand_i = 32'd5;
      multiplier_i   = 32'h0000FFFF;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_busy",    32'(busy_o), 32'd0);
      check("abort_done",    32'(done_o), 32'd0);
      check("abort_product", product_o,   32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done_o) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      run_op("after_abort_2x3", 32'd2, 32'd3, 32'd6, 3, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
